id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register_pkg.sv | 43 ++++
 rtl/id_ex_register_load_use_detect.sv | 29 ++
 rtl/id_ex_register.sv | 190 +++++++++++++++++++
 tb/tb_id_ex_register.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_register_pkg.sv
// Shared pipeline definitions: ID/EX sequencing states, ALU operation codes,
// forwarding-select encodings and the register-match helper used by hazard logic.
package id_ex_register_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } idExState_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_ADDU = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_SUBU = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_SLL  = 4'hA,
    ALU_SRL  = 4'hB,
    ALU_SRA  = 4'hC,
    ALU_LUI  = 4'hD
  } aluOp_t;

  // Operand mux selects produced by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_SHAMT_IMMED = 2'b00,
    FWD_MEM         = 2'b01,
    FWD_EX          = 2'b10,
    FWD_REG         = 2'b11
  } fwdSel_t;

  function automatic logic regMatch(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/id_ex_register_load_use_detect.sv
// Combinational load-use hazard detector: flags an ID instruction that reads
// the destination of a load currently sitting in EX.
module load_use_detect
  import id_ex_register_pkg::*;
(
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRw,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUseShamt,
  input  logic                  idUseImmed,
  input  logic                  idMemWrite,
  output logic                  hazard
);

  logic loadInEx;
  logic rsHit;
  logic rtHit;

  // Rt is still read as store data even when the ALU takes the immediate.
  always_comb begin
    loadInEx = exValid & exMemRead & (exRw != REG_ZERO);
    rsHit    = regMatch(idRs, exRw) & ~idUseShamt;
    rtHit    = regMatch(idRt, exRw) & (~idUseImmed | idMemWrite);
    hazard   = loadInEx & (rsHit | rtHit);
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use stall sequencing, flush-to-bubble
// and a saturating count of inserted load-use bubbles.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic [DATA_W-1:0] ID_BusA,
  input  logic [DATA_W-1:0] ID_BusB,
  input  logic [DATA_W-1:0] ID_Immed,
  input  logic [4:0]        ID_Shamt,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rw,
  input  logic              ID_UseShamt,
  input  logic              ID_UseImmed,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic [3:0]        ID_ALUOp,
  input  logic [1:0]        ID_AluOpCtrlA,
  input  logic [1:0]        ID_AluOpCtrlB,
  input  logic              ID_DataMemFwdEX,
  input  logic              ID_DataMemFwdMEM,
  input  logic              Flush,
  output logic [DATA_W-1:0] EX_BusA,
  output logic [DATA_W-1:0] EX_BusB,
  output logic [DATA_W-1:0] EX_Immed,
  output logic [4:0]        EX_Shamt,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_Rw,
  output logic              EX_UseShamt,
  output logic              EX_UseImmed,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg,
  output logic [3:0]        EX_ALUOp,
  output logic [1:0]        EX_AluOpCtrlA,
  output logic [1:0]        EX_AluOpCtrlB,
  output logic              EX_DataMemFwdEX,
  output logic              EX_DataMemFwdMEM,
  output logic              EX_Valid,
  output logic              Stall,
  output logic [CNT_W-1:0]  StallCount
);

  idExState_t stateReg;
  logic       hazard;
  logic       loadBubble;
  logic       countSat;

  logic [DATA_W-1:0] busANext, busBNext, immedNext;
  logic [4:0]        shamtNext, rsNext, rtNext, rwNext;
  logic              useShamtNext, useImmedNext;
  logic              regWriteNext, memReadNext, memWriteNext, memToRegNext;
  logic [3:0]        aluOpNext;
  logic [1:0]        ctrlANext, ctrlBNext;
  logic              fwdExNext, fwdMemNext;
  logic              validNext;

  load_use_detect uDetect (
    .exValid    (EX_Valid),
    .exMemRead  (EX_MemRead),
    .exRw       (EX_Rw),
    .idRs       (ID_Rs),
    .idRt       (ID_Rt),
    .idUseShamt (ID_UseShamt),
    .idUseImmed (ID_UseImmed),
    .idMemWrite (ID_MemWrite),
    .hazard     (hazard)
  );

  // A flush wins over a stall; in BUBBLE the held instruction proceeds.
  assign Stall    = hazard & ~Flush & (stateReg == ST_RUN);
  assign countSat = &StallCount;

  always_comb begin
    loadBubble   = Flush | Stall;
    validNext    = ~loadBubble;
    busANext     = '0;
    busBNext     = '0;
    immedNext    = '0;
    shamtNext    = '0;
    rsNext       = '0;
    rtNext       = '0;
    rwNext       = '0;
    useShamtNext = 1'b0;
    useImmedNext = 1'b0;
    regWriteNext = 1'b0;
    memReadNext  = 1'b0;
    memWriteNext = 1'b0;
    memToRegNext = 1'b0;
    aluOpNext    = '0;
    ctrlANext    = '0;
    ctrlBNext    = '0;
    fwdExNext    = 1'b0;
    fwdMemNext   = 1'b0;
    if (!loadBubble) begin
      busANext     = ID_BusA;
      busBNext     = ID_BusB;
      immedNext    = ID_Immed;
      shamtNext    = ID_Shamt;
      rsNext       = ID_Rs;
      rtNext       = ID_Rt;
      rwNext       = ID_Rw;
      useShamtNext = ID_UseShamt;
      useImmedNext = ID_UseImmed;
      regWriteNext = ID_RegWrite;
      memReadNext  = ID_MemRead;
      memWriteNext = ID_MemWrite;
      memToRegNext = ID_MemToReg;
      aluOpNext    = ID_ALUOp;
      ctrlANext    = ID_AluOpCtrlA;
      ctrlBNext    = ID_AluOpCtrlB;
      fwdExNext    = ID_DataMemFwdEX;
      fwdMemNext   = ID_DataMemFwdMEM;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      stateReg <= ST_RUN;
    end else begin
      case (stateReg)
        ST_RUN:    stateReg <= Stall ? ST_BUBBLE : ST_RUN;
        ST_BUBBLE: stateReg <= ST_RUN;
        default:   stateReg <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      StallCount <= '0;
    end else if (Stall && !countSat) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      EX_BusA          <= '0;
      EX_BusB          <= '0;
      EX_Immed         <= '0;
      EX_Shamt         <= '0;
      EX_Rs            <= '0;
      EX_Rt            <= '0;
      EX_Rw            <= '0;
      EX_UseShamt      <= 1'b0;
      EX_UseImmed      <= 1'b0;
      EX_RegWrite      <= 1'b0;
      EX_MemRead       <= 1'b0;
      EX_MemWrite      <= 1'b0;
      EX_MemToReg      <= 1'b0;
      EX_ALUOp         <= '0;
      EX_AluOpCtrlA    <= '0;
      EX_AluOpCtrlB    <= '0;
      EX_DataMemFwdEX  <= 1'b0;
      EX_DataMemFwdMEM <= 1'b0;
      EX_Valid         <= 1'b0;
    end else begin
      EX_BusA          <= busANext;
      EX_BusB          <= busBNext;
      EX_Immed         <= immedNext;
      EX_Shamt         <= shamtNext;
      EX_Rs            <= rsNext;
      EX_Rt            <= rtNext;
      EX_Rw            <= rwNext;
      EX_UseShamt      <= useShamtNext;
      EX_UseImmed      <= useImmedNext;
      EX_RegWrite      <= regWriteNext;
      EX_MemRead       <= memReadNext;
      EX_MemWrite      <= memWriteNext;
      EX_MemToReg      <= memToRegNext;
      EX_ALUOp         <= aluOpNext;
      EX_AluOpCtrlA    <= ctrlANext;
      EX_AluOpCtrlB    <= ctrlBNext;
      EX_DataMemFwdEX  <= fwdExNext;
      EX_DataMemFwdMEM <= fwdMemNext;
      EX_Valid         <= validNext;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed hazard scenarios, random
// traffic and counter saturation checked against a cycle-level reference model.
module tb_id_ex_register;

  localparam int DW = 32;
  localparam int CW = 8;   // narrow counter so saturation is reachable quickly

  typedef struct packed {
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] immed;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rw;
    logic        useShamt;
    logic        useImmed;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic [3:0]  aluOp;
    logic [1:0]  ctrlA;
    logic [1:0]  ctrlB;
    logic        fwdEx;
    logic        fwdMem;
  } fields_t;

  logic    CLK;
  logic    Reset_L;
  logic    Flush;
  fields_t id;
  fields_t exObs;

  logic [DW-1:0] EX_BusA, EX_BusB, EX_Immed;
  logic [4:0]    EX_Shamt, EX_Rs, EX_Rt, EX_Rw;
  logic          EX_UseShamt, EX_UseImmed, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
  logic [3:0]    EX_ALUOp;
  logic [1:0]    EX_AluOpCtrlA, EX_AluOpCtrlB;
  logic          EX_DataMemFwdEX, EX_DataMemFwdMEM, EX_Valid, Stall;
  logic [CW-1:0] StallCount;

  // reference model state
  fields_t mEx;
  logic    mValid;
  logic    mPrevStall;
  int      mCount;
  bit      modelKnown;
  logic    expStall;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  id_ex_register #(.DATA_W(DW), .CNT_W(CW)) dut (
    .CLK              (CLK),
    .Reset_L          (Reset_L),
    .ID_BusA          (id.busA),
    .ID_BusB          (id.busB),
    .ID_Immed         (id.immed),
    .ID_Shamt         (id.shamt),
    .ID_Rs            (id.rs),
    .ID_Rt            (id.rt),
    .ID_Rw            (id.rw),
    .ID_UseShamt      (id.useShamt),
    .ID_UseImmed      (id.useImmed),
    .ID_RegWrite      (id.regWrite),
    .ID_MemRead       (id.memRead),
    .ID_MemWrite      (id.memWrite),
    .ID_MemToReg      (id.memToReg),
    .ID_ALUOp         (id.aluOp),
    .ID_AluOpCtrlA    (id.ctrlA),
    .ID_AluOpCtrlB    (id.ctrlB),
    .ID_DataMemFwdEX  (id.fwdEx),
    .ID_DataMemFwdMEM (id.fwdMem),
    .Flush            (Flush),
    .EX_BusA          (EX_BusA),
    .EX_BusB          (EX_BusB),
    .EX_Immed         (EX_Immed),
    .EX_Shamt         (EX_Shamt),
    .EX_Rs            (EX_Rs),
    .EX_Rt            (EX_Rt),
    .EX_Rw            (EX_Rw),
    .EX_UseShamt      (EX_UseShamt),
    .EX_UseImmed      (EX_UseImmed),
    .EX_RegWrite      (EX_RegWrite),
    .EX_MemRead       (EX_MemRead),
    .EX_MemWrite      (EX_MemWrite),
    .EX_MemToReg      (EX_MemToReg),
    .EX_ALUOp         (EX_ALUOp),
    .EX_AluOpCtrlA    (EX_AluOpCtrlA),
    .EX_AluOpCtrlB    (EX_AluOpCtrlB),
    .EX_DataMemFwdEX  (EX_DataMemFwdEX),
    .EX_DataMemFwdMEM (EX_DataMemFwdMEM),
    .EX_Valid         (EX_Valid),
    .Stall            (Stall),
    .StallCount       (StallCount)
  );

  assign exObs = {EX_BusA, EX_BusB, EX_Immed, EX_Shamt, EX_Rs, EX_Rt, EX_Rw,
                  EX_UseShamt, EX_UseImmed, EX_RegWrite, EX_MemRead, EX_MemWrite,
                  EX_MemToReg, EX_ALUOp, EX_AluOpCtrlA, EX_AluOpCtrlB,
                  EX_DataMemFwdEX, EX_DataMemFwdMEM};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load an instruction into ID with random payload and the given register/control fields.
  task automatic setInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                          input logic useShamt, input logic useImmed,
                          input logic memRead, input logic memWrite);
    id.busA     = $urandom;
    id.busB     = $urandom;
    id.immed    = $urandom;
    id.shamt    = 5'($urandom);
    id.rs       = rs;
    id.rt       = rt;
    id.rw       = rw;
    id.useShamt = useShamt;
    id.useImmed = useImmed;
    id.memRead  = memRead;
    id.memWrite = memWrite;
    id.regWrite = ~memWrite;
    id.memToReg = memRead;
    id.aluOp    = 4'($urandom);
    id.ctrlA    = 2'($urandom);
    id.ctrlB    = 2'($urandom);
    id.fwdEx    = 1'($urandom);
    id.fwdMem   = 1'($urandom);
  endtask

  // One clock: predict Stall from the rules, clock, then compare the EX register image.
  task automatic step(input string tag);
    logic hz;
    #1;
    hz = mValid & mEx.memRead & (mEx.rw != 5'd0) &
         (((id.rs == mEx.rw) & ~id.useShamt) |
          ((id.rt == mEx.rw) & (~id.useImmed | id.memWrite)));
    expStall = Reset_L & hz & ~Flush & ~mPrevStall;
    if (Reset_L && modelKnown) chk({tag, ".stall"}, 136'(Stall), 136'(expStall));
    @(posedge CLK);
    #1;
    if (!Reset_L) begin
      mEx        = '0;
      mValid     = 1'b0;
      mPrevStall = 1'b0;
      mCount     = 0;
      modelKnown = 1'b1;
    end else begin
      mValid     = ~(Flush | expStall);
      mEx        = mValid ? id : '0;
      mPrevStall = expStall;
      if (expStall && mCount < (1 << CW) - 1) mCount = mCount + 1;
    end
    chk({tag, ".ex"}, 136'(exObs), 136'(mEx));
    chk({tag, ".valid"}, 136'(EX_Valid), 136'(mValid));
    chk({tag, ".count"}, 136'(StallCount), 136'(mCount));
    txn++;
    $display("txn %0d %s rst_l=%0b flush=%0b stall=%0b ex_valid=%0b ex_rw=%0d count=%0d",
             txn, tag, Reset_L, Flush, expStall, EX_Valid, EX_Rw, StallCount);
  endtask

  initial begin
    mEx = '0; mValid = 1'b0; mPrevStall = 1'b0; mCount = 0; modelKnown = 1'b0;
    expStall = 1'b0;
    Reset_L = 1'b0;
    Flush   = 1'b0;
    setInstr(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;

    // reset state
    step("reset0");
    step("reset1");
    chk("reset.allzero", 136'({exObs, EX_Valid, StallCount}), 136'(0));
    Reset_L = 1'b1;

    // lw $5 ; add $6,$5,$7
    setInstr(5'd2, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lw5");
    setInstr(5'd5, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step("add_dep");
    chk("add_dep.stall1", 136'(expStall), 136'(1));
    chk("add_dep.bubble", 136'({EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Rw}), 136'(0));
    step("add_held");
    chk("add_held.valid", 136'({EX_Valid, EX_Rw}), 136'({1'b1, 5'd6}));
    chk("add_held.count1", 136'(StallCount), 136'(1));

    // lw $5 ; addi $6,$5,4 stalls on Rs
    setInstr(5'd2, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lw5b");
    setInstr(5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    step("addi_dep");
    chk("addi_dep.stall", 136'(expStall), 136'(1));
    step("addi_held");

    // lw $0 ; add using $0 never stalls
    setInstr(5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lw0");
    setInstr(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step("add_r0");
    chk("add_r0.nostall", 136'({expStall, EX_Valid}), 136'({1'b0, 1'b1}));

    // lw $5 ; sw $5,0($8) stalls on store data
    setInstr(5'd2, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lw5c");
    setInstr(5'd8, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("sw_dep");
    chk("sw_dep.stall", 136'(expStall), 136'(1));
    step("sw_held");
    setInstr(5'd2, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lw5d");
    setInstr(5'd8, 5'd5, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step("immed_rt");
    chk("immed_rt.nostall", 136'(expStall), 136'(0));

    // hazard coinciding with flush: flush wins, count unchanged
    setInstr(5'd2, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lw5e");
    setInstr(5'd5, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    Flush = 1'b1;
    step("flush_hz");
    chk("flush_hz.bubble", 136'({expStall, EX_Valid, StallCount}), 136'({1'b0, 1'b0, 8'd2 + 8'd1}));
    Flush = 1'b0;
    step("after_flush");
    chk("after_flush.valid", 136'(EX_Valid), 136'(1));

    // random traffic over a small register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      setInstr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2));
      Flush = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    Flush = 1'b0;

    // self-dependent load stream drives the counter into saturation
    for (int i = 0; i < 600; i++) begin
      setInstr(5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      step("sat");
    end
    chk("sat.allones", 136'(StallCount), 136'({CW{1'b1}}));

    // reset while in BUBBLE
    for (int i = 0; i < 4 && !mPrevStall; i++) step("seek_bubble");
    chk("seek_bubble.inbubble", 136'(mPrevStall), 136'(1));
    Reset_L = 1'b0;
    step("rst_bubble");
    chk("rst_bubble.zero", 136'({exObs, EX_Valid, StallCount}), 136'(0));
    Reset_L = 1'b1;
    setInstr(5'd5, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst");
    chk("post_rst.valid", 136'({EX_Valid, EX_Rw}), 136'({1'b1, 5'd6}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
